// File: rtl/matrix_mult_engine_if.sv
// Stream bundle between a host and the matrix multiply engine: operand write
// stream, result read stream and the busy flag.
interface matrix_mult_engine_if #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned NUM_ELEMENTS = 4,
  parameter int unsigned MATRIX_WIDTH = 4,
  parameter int unsigned OUT_WIDTH    = 2 * WIDTH + $clog2(MATRIX_WIDTH)
);
  logic [NUM_ELEMENTS*WIDTH-1:0]     wdata;
  logic                              write_en;
  logic                              write_ready;
  logic [NUM_ELEMENTS*OUT_WIDTH-1:0] rdata;
  logic                              read_en;
  logic                              read_ready;
  logic                              busy;

  modport master (
    output wdata, write_en, read_en,
    input  write_ready, rdata, read_ready, busy
  );

  modport slave (
    input  wdata, write_en, read_en,
    output write_ready, rdata, read_ready, busy
  );
endinterface

// File: rtl/matrix_mult_engine.sv
// Square matrix multiplier C = A x B. A then B are streamed in row-major beats
// of NUM_ELEMENTS operands, NUM_ELEMENTS MAC lanes compute one result beat per
// N cycles, and C is streamed back out with full-precision elements.
module matrix_mult_engine #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned NUM_ELEMENTS = 4,
  parameter int unsigned MATRIX_WIDTH = 4,
  parameter int unsigned SIGNED       = 0,
  parameter int unsigned OUT_WIDTH    = 2 * WIDTH + $clog2(MATRIX_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  matrix_mult_engine_if.slave  bus
);

  localparam int unsigned NE     = NUM_ELEMENTS;
  localparam int unsigned N      = MATRIX_WIDTH;
  localparam int unsigned BPR    = N / NE;
  localparam int unsigned BEATS  = N * N / NE;
  localparam int unsigned ELEMS  = N * N;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned EL_W   = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int unsigned K_W    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned JB_W   = (BPR > 1) ? $clog2(BPR) : 1;

  typedef enum logic [1:0] {
    S_LOAD_A  = 2'd0,
    S_LOAD_B  = 2'd1,
    S_COMPUTE = 2'd2,
    S_DRAIN   = 2'd3
  } state_e;

  state_e                       state_q, state_d;
  logic [BEAT_W-1:0]            wr_cnt_q, wr_cnt_d;
  logic [BEAT_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [K_W-1:0]               i_q, i_d;
  logic [K_W-1:0]               k_q, k_d;
  logic [JB_W-1:0]              jb_q, jb_d;
  logic [OUT_WIDTH-1:0]         acc_q [NE];
  logic [OUT_WIDTH-1:0]         acc_d [NE];
  logic                         write_ready_q, write_ready_d;
  logic                         read_ready_q, read_ready_d;
  logic                         busy_q, busy_d;
  logic [NE*OUT_WIDTH-1:0]      rdata_q, rdata_d;

  logic [WIDTH-1:0]             a_mem [ELEMS];
  logic [WIDTH-1:0]             b_mem [ELEMS];
  logic [OUT_WIDTH-1:0]         c_mem [ELEMS];

  logic                         wr_acc, rd_acc;
  logic                         a_we, b_we, c_we;
  logic [BEAT_W-1:0]            c_idx;
  logic [NE*OUT_WIDTH-1:0]      c_beat;
  logic [EL_W-1:0]              a_idx;
  logic [EL_W-1:0]              b_idx [NE];
  logic [OUT_WIDTH-1:0]         a_ext;
  logic [OUT_WIDTH-1:0]         b_ext [NE];
  logic [OUT_WIDTH-1:0]         sum   [NE];

  assign wr_acc = bus.write_en & write_ready_q;
  assign rd_acc = bus.read_en & read_ready_q;

  assign bus.write_ready = write_ready_q;
  assign bus.read_ready  = read_ready_q;
  assign bus.busy        = busy_q;
  assign bus.rdata       = rdata_q;

  // Widen an operand to the result width; modular arithmetic at OUT_WIDTH is exact.
  function automatic logic [OUT_WIDTH-1:0] ext(input logic [WIDTH-1:0] x);
    logic sx;
    sx = (SIGNED != 0) ? x[WIDTH-1] : 1'b0;
    return {{(OUT_WIDTH-WIDTH){sx}}, x};
  endfunction

  // Next-state, MAC datapath and registered-output next values.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_ptr_d = rd_ptr_q;
    i_d      = i_q;
    k_d      = k_q;
    jb_d     = jb_q;
    acc_d    = acc_q;
    a_we     = 1'b0;
    b_we     = 1'b0;
    c_we     = 1'b0;
    c_beat   = '0;
    c_idx    = BEAT_W'(BEAT_W'(i_q) * BEAT_W'(BPR) + BEAT_W'(jb_q));
    a_idx    = EL_W'(EL_W'(i_q) * EL_W'(N) + EL_W'(k_q));
    a_ext    = ext(a_mem[a_idx]);
    for (int e = 0; e < int'(NE); e++) begin
      b_idx[e] = EL_W'(EL_W'(k_q) * EL_W'(N) + EL_W'(jb_q) * EL_W'(NE) + EL_W'(e));
      b_ext[e] = ext(b_mem[b_idx[e]]);
      sum[e]   = ((k_q == '0) ? '0 : acc_q[e]) + OUT_WIDTH'(a_ext * b_ext[e]);
    end

    case (state_q)
      S_LOAD_A: begin
        if (wr_acc) begin
          a_we = 1'b1;
          if (wr_cnt_q == BEAT_W'(BEATS - 1)) begin
            wr_cnt_d = '0;
            state_d  = S_LOAD_B;
          end else begin
            wr_cnt_d = wr_cnt_q + BEAT_W'(1);
          end
        end
      end
      S_LOAD_B: begin
        if (wr_acc) begin
          b_we = 1'b1;
          if (wr_cnt_q == BEAT_W'(BEATS - 1)) begin
            wr_cnt_d = '0;
            state_d  = S_COMPUTE;
            i_d      = '0;
            jb_d     = '0;
            k_d      = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + BEAT_W'(1);
          end
        end
      end
      S_COMPUTE: begin
        acc_d = sum;
        for (int e = 0; e < int'(NE); e++) begin
          c_beat[e*OUT_WIDTH +: OUT_WIDTH] = sum[e];
        end
        if (k_q == K_W'(N - 1)) begin
          c_we = 1'b1;
          k_d  = '0;
          if (jb_q == JB_W'(BPR - 1)) begin
            jb_d = '0;
            if (i_q == K_W'(N - 1)) begin
              i_d     = '0;
              state_d = S_DRAIN;
            end else begin
              i_d = i_q + K_W'(1);
            end
          end else begin
            jb_d = jb_q + JB_W'(1);
          end
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      S_DRAIN: begin
        if (rd_acc) begin
          if (rd_ptr_q == BEAT_W'(BEATS - 1)) begin
            rd_ptr_d = '0;
            state_d  = S_LOAD_A;
          end else begin
            rd_ptr_d = rd_ptr_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = S_LOAD_A;
    endcase

    write_ready_d = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
    read_ready_d  = (state_d == S_DRAIN);
    busy_d        = (state_d == S_COMPUTE) || (state_d == S_DRAIN);
    rdata_d       = '0;
    if (state_d == S_DRAIN) begin
      // Forward a result beat that is being written on this same edge.
      if (c_we && (c_idx == rd_ptr_d)) begin
        rdata_d = c_beat;
      end else begin
        for (int e = 0; e < int'(NE); e++) begin
          rdata_d[e*OUT_WIDTH +: OUT_WIDTH] =
            c_mem[EL_W'(EL_W'(rd_ptr_d) * EL_W'(NE) + EL_W'(e))];
        end
      end
    end
  end

  // Control state, counters, accumulators and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_LOAD_A;
      wr_cnt_q      <= '0;
      rd_ptr_q      <= '0;
      i_q           <= '0;
      k_q           <= '0;
      jb_q          <= '0;
      write_ready_q <= 1'b0;
      read_ready_q  <= 1'b0;
      busy_q        <= 1'b0;
      rdata_q       <= '0;
      for (int e = 0; e < int'(NE); e++) begin
        acc_q[e] <= '0;
      end
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      i_q           <= i_d;
      k_q           <= k_d;
      jb_q          <= jb_d;
      write_ready_q <= write_ready_d;
      read_ready_q  <= read_ready_d;
      busy_q        <= busy_d;
      rdata_q       <= rdata_d;
      acc_q         <= acc_d;
    end
  end

  // Operand and result storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    for (int e = 0; e < int'(NE); e++) begin
      if (a_we) begin
        a_mem[EL_W'(EL_W'(wr_cnt_q) * EL_W'(NE) + EL_W'(e))] <= bus.wdata[e*WIDTH +: WIDTH];
      end
      if (b_we) begin
        b_mem[EL_W'(EL_W'(wr_cnt_q) * EL_W'(NE) + EL_W'(e))] <= bus.wdata[e*WIDTH +: WIDTH];
      end
      if (c_we) begin
        c_mem[EL_W'(EL_W'(c_idx) * EL_W'(NE) + EL_W'(e))] <= c_beat[e*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_matrix_mult_engine.sv
// Bench for matrix_mult_engine: an unsigned and a signed instance run in
// lock-step on identical stimulus and are checked against a plain-arithmetic
// matrix product model.
module tb_matrix_mult_engine;
  localparam int unsigned W  = 8;
  localparam int unsigned NE = 4;
  localparam int unsigned N  = 4;
  localparam int unsigned OW = 18;

  logic clk = 1'b0;
  logic reset;
  logic [NE*W-1:0] wdata;
  logic write_en;
  logic read_en;

  always #5 clk = ~clk;

  matrix_mult_engine_if #(.WIDTH(W), .NUM_ELEMENTS(NE), .MATRIX_WIDTH(N), .OUT_WIDTH(OW)) ifu ();
  matrix_mult_engine_if #(.WIDTH(W), .NUM_ELEMENTS(NE), .MATRIX_WIDTH(N), .OUT_WIDTH(OW)) ifs ();

  assign ifu.wdata    = wdata;
  assign ifu.write_en = write_en;
  assign ifu.read_en  = read_en;
  assign ifs.wdata    = wdata;
  assign ifs.write_en = write_en;
  assign ifs.read_en  = read_en;

  matrix_mult_engine #(.WIDTH(W), .NUM_ELEMENTS(NE), .MATRIX_WIDTH(N), .SIGNED(0), .OUT_WIDTH(OW))
    u_dut (.clk(clk), .reset(reset), .bus(ifu));
  matrix_mult_engine #(.WIDTH(W), .NUM_ELEMENTS(NE), .MATRIX_WIDTH(N), .SIGNED(1), .OUT_WIDTH(OW))
    u_dut_s (.clk(clk), .reset(reset), .bus(ifs));

  int total = 0;
  int bad   = 0;
  logic [W-1:0] ma [N][N];
  logic [W-1:0] mb [N][N];

  // Reference: C[r][c] = sum_k A[r][k]*B[k][c] in wide integer arithmetic.
  function automatic logic [OW-1:0] exp_el(input bit sgn, input int r, input int c);
    longint s = 0;
    longint av, bv;
    for (int k = 0; k < int'(N); k++) begin
      av = sgn ? longint'($signed(ma[r][k])) : longint'(ma[r][k]);
      bv = sgn ? longint'($signed(mb[k][c])) : longint'(mb[k][c]);
      s += av * bv;
    end
    return OW'(s);
  endfunction

  function automatic logic [NE*OW-1:0] exp_beat(input bit sgn, input int row);
    logic [NE*OW-1:0] v;
    for (int e = 0; e < int'(NE); e++) v[e*OW +: OW] = exp_el(sgn, row, e);
    return v;
  endfunction

  task automatic fill_random();
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++) begin
        ma[r][c] = W'($urandom);
        mb[r][c] = W'($urandom);
      end
  endtask

  // Stream A then B; optional random gap cycles with write_en low.
  task automatic load_job(input bit gaps);
    for (int bt = 0; bt < int'(2 * N); bt++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        write_en = 1'b0;
        wdata    = $urandom;
        @(negedge clk);
      end
      for (int e = 0; e < int'(NE); e++)
        wdata[e*W +: W] = (bt < int'(N)) ? ma[bt][e] : mb[bt - int'(N)][e];
      write_en = 1'b1;
      total++;
      if (ifu.write_ready !== 1'b1 || ifs.write_ready !== 1'b1) begin
        bad++;
        $display("FAIL load_ready beat=%0d got u=%b s=%b want 1", bt, ifu.write_ready, ifs.write_ready);
      end
      @(negedge clk);
    end
    write_en = 1'b0;
  endtask

  // Called at the first negedge after the last B accept.
  task automatic wait_result();
    int cyc = 0;
    total++;
    if (ifu.busy !== 1'b1 || ifs.busy !== 1'b1 || ifu.write_ready !== 1'b0 || ifs.write_ready !== 1'b0) begin
      bad++;
      $display("FAIL compute_entry got busy=%b/%b wr_rdy=%b/%b want busy=1 wr_rdy=0",
               ifu.busy, ifs.busy, ifu.write_ready, ifs.write_ready);
    end
    while (ifu.read_ready !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc != 16 || ifs.read_ready !== 1'b1) begin
      bad++;
      $display("FAIL latency got %0d cycles (s_rdy=%b) want 16", cyc, ifs.read_ready);
    end
  endtask

  // Read all result beats; bp stalls two cycles before each beat after the first.
  task automatic drain_job(input bit bp, input bit poke);
    logic [NE*OW-1:0] eu, es;
    int st;
    for (int bt = 0; bt < int'(N); bt++) begin
      eu = exp_beat(1'b0, bt);
      es = exp_beat(1'b1, bt);
      st = (bp && bt > 0) ? 2 : 0;
      for (int s = 0; s < st; s++) begin
        read_en = 1'b0;
        if (poke) begin
          write_en = 1'b1;
          wdata    = $urandom;
        end
        @(negedge clk);
        total++;
        if (ifu.rdata !== eu || ifs.rdata !== es || ifu.read_ready !== 1'b1 || ifu.write_ready !== 1'b0) begin
          bad++;
          $display("FAIL stall_hold beat=%0d got u=%h s=%h rdy=%b wr=%b want u=%h s=%h rdy=1 wr=0",
                   bt, ifu.rdata, ifs.rdata, ifu.read_ready, ifu.write_ready, eu, es);
        end
      end
      write_en = 1'b0;
      total++;
      if (ifu.rdata !== eu || ifs.rdata !== es || ifu.read_ready !== 1'b1 || ifs.read_ready !== 1'b1) begin
        bad++;
        $display("FAIL result beat=%0d got u=%h s=%h rdy=%b/%b want u=%h s=%h rdy=1",
                 bt, ifu.rdata, ifs.rdata, ifu.read_ready, ifs.read_ready, eu, es);
      end
      read_en = 1'b1;
      @(negedge clk);
    end
    read_en = 1'b0;
    total++;
    if (ifu.read_ready !== 1'b0 || ifu.busy !== 1'b0 || ifu.write_ready !== 1'b1 ||
        ifs.write_ready !== 1'b1 || ifu.rdata !== '0) begin
      bad++;
      $display("FAIL drain_exit got rdy=%b busy=%b wr=%b/%b rdata=%h want rdy=0 busy=0 wr=1 rdata=0",
               ifu.read_ready, ifu.busy, ifu.write_ready, ifs.write_ready, ifu.rdata);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    write_en = 1'b1;
    read_en  = 1'b0;
    wdata    = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (ifu.write_ready !== 1'b0 || ifs.write_ready !== 1'b0 || ifu.read_ready !== 1'b0 ||
          ifu.busy !== 1'b0 || ifu.rdata !== '0 || ifs.rdata !== '0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got wr=%b/%b rdy=%b busy=%b rdata=%h want all 0",
                 c, ifu.write_ready, ifs.write_ready, ifu.read_ready, ifu.busy, ifu.rdata);
      end
    end
    reset    = 1'b1;
    write_en = 1'b0;
    @(negedge clk);
    total++;
    if (ifu.write_ready !== 1'b1 || ifs.write_ready !== 1'b1 || ifu.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got wr=%b/%b busy=%b want wr=1 busy=0",
               ifu.write_ready, ifs.write_ready, ifu.busy);
    end
  endtask

  task automatic test_identity();
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++) begin
        ma[r][c] = (r == c) ? W'(1) : W'(0);
        mb[r][c] = W'(4 * r + c);
      end
    load_job(1'b0);
    wait_result();
    drain_job(1'b0, 1'b0);
  endtask

  task automatic test_max_unsigned();
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++) begin
        ma[r][c] = 8'hFF;
        mb[r][c] = 8'hFF;
      end
    load_job(1'b0);
    wait_result();
    total++;
    if (ifu.rdata[OW-1:0] !== 18'h3F804) begin
      bad++;
      $display("FAIL max_unsigned got %h want 3f804", ifu.rdata[OW-1:0]);
    end
    drain_job(1'b0, 1'b0);
  endtask

  task automatic test_signed();
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++) begin
        ma[r][c] = 8'h80;
        mb[r][c] = 8'h80;
      end
    load_job(1'b0);
    wait_result();
    total++;
    if (ifs.rdata[OW-1:0] !== 18'd65536) begin
      bad++;
      $display("FAIL signed_min got %h want 10000", ifs.rdata[OW-1:0]);
    end
    drain_job(1'b0, 1'b0);
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++) begin
        ma[r][c] = 8'hFF;
        mb[r][c] = 8'h01;
      end
    load_job(1'b0);
    wait_result();
    total++;
    if (ifs.rdata[OW-1:0] !== 18'h3FFFC) begin
      bad++;
      $display("FAIL signed_neg got %h want 3fffc", ifs.rdata[OW-1:0]);
    end
    drain_job(1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    fill_random();
    load_job(1'b1);
    wait_result();
    drain_job(1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 3; j++) begin
      fill_random();
      load_job(1'b0);
      wait_result();
      drain_job(j == 1, 1'b0);
    end
  endtask

  task automatic test_abort();
    fill_random();
    load_job(1'b0);
    repeat (8) @(negedge clk);
    total++;
    if (ifu.busy !== 1'b1 || ifu.read_ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_precond got busy=%b rdy=%b want busy=1 rdy=0", ifu.busy, ifu.read_ready);
    end
    reset = 1'b0;
    #1;
    total++;
    if (ifu.busy !== 1'b0 || ifs.busy !== 1'b0 || ifu.write_ready !== 1'b0 ||
        ifu.read_ready !== 1'b0 || ifu.rdata !== '0) begin
      bad++;
      $display("FAIL abort_reset got busy=%b/%b wr=%b rdy=%b rdata=%h want all 0",
               ifu.busy, ifs.busy, ifu.write_ready, ifu.read_ready, ifu.rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    fill_random();
    load_job(1'b1);
    wait_result();
    drain_job(1'b0, 1'b0);
  endtask

  initial begin
    reset    = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    wdata    = '0;
    test_reset();
    test_identity();
    test_max_unsigned();
    test_signed();
    test_backpressure();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
